cla_adder_arbiter: RTL and testbench

CLA_ADDER_ARBITER -- requirements
Module: cla_adder_arbiter

---
 rtl/cla_adder_arbiter_pkg.sv | 23 ++
 rtl/cla_add2.sv | 24 ++
 rtl/cla_adder_arbiter.sv | 133 +++++++++++++
 tb/tb_cla_adder_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_adder_arbiter_pkg.sv
// Shared definitions for the two-requester CLA adder arbiter.
//   - FSM state encoding (2-bit)
//   - HOLD down-counter width and type
//   - seven-segment patterns for digits 0..6 plus blank (bit0=a ... bit6=g, active high)
package cla_adder_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam int unsigned HOLD_CNT_W = 8;
    typedef logic [HOLD_CNT_W-1:0] hold_cnt_t;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/cla_add2.sv
// 2-bit carry-lookahead adder, no carry in.
// Ports:
//   a, b : 2-bit unsigned operands
//   s    : 3-bit sum, carry out in bit 2
module cla_add2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [2:0] s
);

    logic [1:0] g;
    logic [1:0] p;
    logic       c1;
    logic       c2;

    always_comb begin
        g  = a & b;
        p  = a ^ b;
        c1 = g[0];
        c2 = g[1] | (p[1] & g[0]);
        s  = {c2, p[1] ^ c1, p[0]};
    end

endmodule

// File: rtl/cla_adder_arbiter.sv
// Round-robin arbiter in front of a shared 2-bit CLA adder with a seven-segment readout.
// A granted requester's operands are latched in IDLE, added in ADD, and the result is
// held for HOLD_CYCLES cycles (starting with the ack cycle) before the next grant.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   req0, req1        : requests
//   a0, b0, a1, b1    : 2-bit operands per requester
//   ack0, ack1        : one-cycle completion pulse to the granted requester
//   sum               : registered 3-bit result
//   sum_valid         : high from the ack cycle until the FSM returns to IDLE
//   owner             : requester whose result is on sum
//   segt              : seven-segment pattern of sum, blank before the first result
module cla_adder_arbiter
    import cla_adder_arbiter_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [1:0] a0,
    input  logic [1:0] b0,
    input  logic [1:0] a1,
    input  logic [1:0] b1,
    output logic       ack0,
    output logic       ack1,
    output logic [2:0] sum,
    output logic       sum_valid,
    output logic       owner,
    output logic [6:0] segt
);

    logic [1:0] state;
    logic [1:0] state_d;
    hold_cnt_t  hold_cnt;
    logic       last_grant;  // requester granted most recently; a tie goes to the other one
    logic       cur;         // requester owning the transaction in flight
    logic [1:0] op_a;
    logic [1:0] op_b;
    logic       shown;       // a result has been produced since reset
    logic       any_req;
    logic       pick;
    logic [2:0] add_s;

    cla_add2 u_add (
        .a (op_a),
        .b (op_b),
        .s (add_s)
    );

    always_comb begin
        any_req = req0 | req1;
        // A lone request wins outright; a tie alternates.
        pick    = (req0 && req1) ? ~last_grant : req1;
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: if (any_req) state_d = ST_ADD;
            ST_ADD:  state_d = ST_HOLD;
            ST_HOLD: if (hold_cnt == '0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            hold_cnt   <= '0;
            last_grant <= 1'b1;
            cur        <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            shown      <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            sum        <= '0;
            sum_valid  <= 1'b0;
            owner      <= 1'b0;
        end else begin
            state <= state_d;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        cur        <= pick;
                        last_grant <= pick;
                        op_a       <= pick ? a1 : a0;
                        op_b       <= pick ? b1 : b0;
                    end
                end
                ST_ADD: begin
                    sum       <= add_s;
                    owner     <= cur;
                    sum_valid <= 1'b1;
                    shown     <= 1'b1;
                    ack0      <= ~cur;
                    ack1      <= cur;
                    hold_cnt  <= hold_cnt_t'(HOLD_CYCLES - 1);
                end
                ST_HOLD: begin
                    if (hold_cnt == '0) begin
                        sum_valid <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    function automatic logic [6:0] seg_decode(input logic [2:0] v);
        case (v)
            3'd0:    return SEG_0;
            3'd1:    return SEG_1;
            3'd2:    return SEG_2;
            3'd3:    return SEG_3;
            3'd4:    return SEG_4;
            3'd5:    return SEG_5;
            3'd6:    return SEG_6;
            default: return SEG_BLANK;
        endcase
    endfunction

    always_comb begin
        segt = shown ? seg_decode(sum) : SEG_BLANK;
    end

endmodule

// File: tb/tb_cla_adder_arbiter.sv
// Self-checking bench for cla_adder_arbiter (HOLD_CYCLES = 2).
module tb_cla_adder_arbiter;

    localparam int H = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [1:0] a0 = '0;
    logic [1:0] b0 = '0;
    logic [1:0] a1 = '0;
    logic [1:0] b1 = '0;
    logic       ack0;
    logic       ack1;
    logic [2:0] sum;
    logic       sum_valid;
    logic       owner;
    logic [6:0] segt;

    cla_adder_arbiter #(.HOLD_CYCLES(H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .ack0      (ack0),
        .ack1      (ack1),
        .sum       (sum),
        .sum_valid (sum_valid),
        .owner     (owner),
        .segt      (segt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic int seg_of(input int v);
        case (v)
            0: return 'h3F;
            1: return 'h06;
            2: return 'h5B;
            3: return 'h4F;
            4: return 'h66;
            5: return 'h6D;
            6: return 'h7D;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: a grant at IDLE sample t yields a result in t+2 and the
    // arbiter samples again at t+2+H.
    initial begin
        int  m_ack_cyc;
        int  m_idle_at;
        int  m_who;
        int  m_s;
        int  m_last;
        int  e_sum;
        int  e_owner;
        int  e_valid;
        int  m_have;
        m_ack_cyc = -1; m_idle_at = 0; m_who = 0; m_s = 0; m_last = 1;
        e_sum = 0; e_owner = 0; e_valid = 0; m_have = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_ack_cyc = -1; m_idle_at = cyc; m_last = 1;
                e_sum = 0; e_owner = 0; e_valid = 0; m_have = 0;
            end else begin
                if (cyc == m_ack_cyc) begin
                    e_sum = m_s; e_owner = m_who; e_valid = 1; m_have = 1;
                end
                if (cyc == m_idle_at) e_valid = 0;
            end
            check("ack0", int'(ack0), int'(rst_n && cyc == m_ack_cyc && m_who == 0));
            check("ack1", int'(ack1), int'(rst_n && cyc == m_ack_cyc && m_who == 1));
            check("sum_valid", int'(sum_valid), e_valid);
            check("sum", int'(sum), e_sum);
            check("owner", int'(owner), e_owner);
            check("segt", int'(segt), m_have != 0 ? seg_of(e_sum) : 0);
            if (rst_n && cyc >= m_idle_at && (req0 || req1)) begin
                if (req0 && req1) m_who = 1 - m_last;
                else m_who = int'(req1);
                m_last = m_who;
                m_s = (m_who == 1) ? int'(a1) + int'(b1) : int'(a0) + int'(b0);
                m_ack_cyc = cyc + 2;
                m_idle_at = cyc + 2 + H;
            end
        end
    end

    task automatic wait_ack(input int who, output int t);
        t = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if ((who == 0 && ack0) || (who == 1 && ack1)) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check("ack_timeout", 0, 1);
    endtask

    task automatic settle();
        repeat (H + 2) @(posedge clk);
        #1;
    endtask

    // Issues one request, drops it right after the ack, returns request-to-ack latency.
    task automatic do_req(input int who, input int a, input int b, output int lat);
        int n;
        int t;
        if (who == 0) begin a0 = 2'(a); b0 = 2'(b); req0 = 1'b1; end
        else begin a1 = 2'(a); b1 = 2'(b); req1 = 1'b1; end
        n = cyc;
        wait_ack(who, t);
        lat = (t < 0) ? -1 : t - n;
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        settle();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int t;
        int n;
        int who_q[$];
        int cyc_q[$];
        int cnt;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_segt", int'(segt), 0);
        check("rst_sum", int'(sum), 0);
        check("rst_valid", int'(sum_valid), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single request: 3 + 2 = 5
        a0 = 2'b11; b0 = 2'b10; req0 = 1'b1;
        n = cyc;
        wait_ack(0, t);
        check("single_lat", t - n, 2);
        check("single_sum", int'(sum), 5);
        check("single_owner", int'(owner), 0);
        check("single_segt", int'(segt), 'h6D);
        check("single_noack1", int'(ack1), 0);
        @(posedge clk);
        #1 req0 = 1'b0;
        @(negedge clk);
        check("single_ack_once", int'(ack0), 0);
        settle();

        // Operand change while holding
        a0 = 2'd1; b0 = 2'd1; req0 = 1'b1;
        wait_ack(0, t);
        @(posedge clk);
        #1 req0 = 1'b0; a0 = 2'd3;
        repeat (3) begin
            @(negedge clk);
            check("hold_sum", int'(sum), 2);
        end
        settle();

        // Full operand sweep on requester 1
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                do_req(1, a, b, lat);
                check("sweep_lat", lat, 2);
                if (a == 0 && b == 0) check("sweep_zero_segt", int'(segt), 'h3F);
                if (a == 3 && b == 3) begin
                    check("sweep_max_sum", int'(sum), 6);
                    check("sweep_max_segt", int'(segt), 'h7D);
                end
            end
        end

        // Continuous tie: 0,1,0,1, four cycles apart
        a0 = 2'd1; b0 = 2'd0; a1 = 2'd2; b1 = 2'd2;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 40 && who_q.size() < 4; k++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                who_q.push_back(int'(ack1));
                cyc_q.push_back(cyc);
            end
        end
        @(posedge clk);
        #1 req0 = 1'b0; req1 = 1'b0;
        check("tie_count", who_q.size(), 4);
        if (who_q.size() == 4) begin
            check("tie_order0", who_q[0], 0);
            check("tie_order1", who_q[1], 1);
            check("tie_order2", who_q[2], 0);
            check("tie_order3", who_q[3], 1);
            check("tie_gap1", cyc_q[1] - cyc_q[0], 4);
            check("tie_gap2", cyc_q[2] - cyc_q[1], 4);
            check("tie_gap3", cyc_q[3] - cyc_q[2], 4);
        end
        settle();

        // Withdrawn request during HOLD
        a0 = 2'd2; b0 = 2'd0; req0 = 1'b1;
        wait_ack(0, t);
        @(posedge clk);
        #1 req0 = 1'b0; req1 = 1'b1;
        @(posedge clk);
        #1 req1 = 1'b0;
        @(negedge clk);
        check("wd_valid", int'(sum_valid), 0);
        check("wd_sum_kept", int'(sum), 2);
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack1) cnt++;
        end
        check("wd_noack1", cnt, 0);

        // Reset in the ADD cycle, request kept pending
        a1 = 2'd1; b1 = 2'd2; req1 = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_ack1", int'(ack1), 0);
        check("mid_rst_sum", int'(sum), 0);
        check("mid_rst_valid", int'(sum_valid), 0);
        check("mid_rst_owner", int'(owner), 0);
        check("mid_rst_segt", int'(segt), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        n = cyc;
        wait_ack(1, t);
        check("post_rst_lat", t - n, 2);
        check("post_rst_sum", int'(sum), 3);
        @(posedge clk);
        #1 req1 = 1'b0;
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
